tx_clk_speed_sequencer: RTL and testbench
=========================================

TX_CLK_SPEED_SEQUENCER -- requirements
Module: tx_clk_speed_sequencer

Interface
REQ-001 SHALL have parameter rst_cycles_p, default 4: cycles clkgen_rst_o is held high per switch (>=1).
REQ-002 SHALL have parameter settle_cycles_p, default 16: cycles waited after clock-generator reset release before ready (>=1).
REQ-003 SHALL have parameter drain_timeout_p, default 4096: maximum DRAIN cycles; used only under REQ-027.
REQ-004 SHALL have port clk250_i, input, 1 bit: the single clock.
REQ-005 SHALL have port clk250_rst_ni, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port speed_req_i, input, 2 bits: requested speed (00=10M, 01=100M, 10=1000M, 11=reserved).
REQ-007 SHALL have port speed_req_v_i, input, 1 bit: request valid.
REQ-008 SHALL have port speed_req_ready_o, output, 1 bit: request accepted when v and ready are both high.
REQ-009 SHALL have port tx_busy_i, input, 1 bit: MAC TX frame in flight.
REQ-010 SHALL have port tx_hold_o, output, 1 bit: MAC must not start a new frame.
REQ-011 SHALL have port clkgen_rst_o, output, 1 bit: active-high reset shared by the RGMII TX clock generator and the GTX clock generator.
REQ-012 SHALL have port clk_setting_o, output, 2 bits: RGMII TX clock setting.
REQ-013 SHALL have port link_ready_o, output, 1 bit: clocks stable, TX permitted.
REQ-014 SHALL have port bad_req_o, output, 1 bit: one-cycle pulse on an accepted reserved request.
REQ-015 SHALL have port timeout_o, output, 1 bit: one-cycle pulse on a drain timeout.

Function
REQ-016 SHALL implement states READY, DRAIN, RESET and SETTLE with one shared down-counter sized for max(rst_cycles_p, settle_cycles_p, drain_timeout_p).
REQ-017 speed_req_ready_o SHALL be 1 only in READY; link_ready_o SHALL be 1 only in READY; tx_hold_o SHALL equal not link_ready_o.
REQ-018 An accepted request equal to the current clk_setting_o, or equal to 11, SHALL leave the FSM in READY with all outputs unchanged; for 11, bad_req_o SHALL pulse in the cycle after acceptance.
REQ-019 An accepted request to a different legal speed at cycle T SHALL latch the speed and enter DRAIN at T+1.
REQ-020 DRAIN SHALL move to RESET in the cycle after the first cycle in which tx_busy_i is sampled 0, including the first DRAIN cycle.
REQ-021 On entering RESET, clk_setting_o SHALL take the latched speed; clkgen_rst_o SHALL be 1 for exactly rst_cycles_p cycles, then the FSM SHALL enter SETTLE.
REQ-022 SETTLE SHALL last exactly settle_cycles_p cycles with clkgen_rst_o=0, then the FSM SHALL enter READY.
REQ-023 clk_setting_o SHALL change only on entry to RESET, so the setting never changes while the clock generators run.
REQ-024 speed_req_i and speed_req_v_i SHALL be ignored outside READY; tx_busy_i SHALL be ignored outside DRAIN.

Reset
REQ-025 While clk250_rst_ni=0, on each clock edge, the block SHALL force: state=RESET with counter=rst_cycles_p; clk_setting_o=10; clkgen_rst_o=1; tx_hold_o=1; link_ready_o=0; speed_req_ready_o=0; bad_req_o=0; timeout_o=0.
REQ-026 After release, the block SHALL run the REQ-021/REQ-022 sequence; reset asserted in any state, mid-switch included, SHALL abandon the pending speed and restart at 1000M.

Configuration
REQ-027 With TX_CLK_SEQ_DRAIN_TIMEOUT_EN defined, DRAIN SHALL proceed to RESET after drain_timeout_p cycles even if tx_busy_i=1, pulsing timeout_o in the first RESET cycle.
REQ-028 Without the macro, DRAIN SHALL wait indefinitely and timeout_o SHALL be constant 0.

Verification
REQ-029 Defaults, release reset at cycle 0 -> clkgen_rst_o=1 for cycles 0-3, link_ready_o=0 through cycle 19 and rises at cycle 20, clk_setting_o=10 throughout.
REQ-030 In READY, request 01 accepted at T with tx_busy_i=0 -> DRAIN at T+1; clk_setting_o=01 and clkgen_rst_o=1 from T+2 to T+5; link_ready_o=1 at T+22.
REQ-031 Request 00 while tx_busy_i=1 for 50 cycles -> stays in DRAIN with tx_hold_o=1 and clk_setting_o unchanged until busy drops; then RESET follows one cycle later.
REQ-032 Request 10 while already at 10, then request 11 -> no state change, link_ready_o stays 1; bad_req_o pulses once for the 11 request only.
REQ-033 clk250_rst_ni driven low during SETTLE of a switch to 00 -> all REQ-025 values at the next edge; after release, clk_setting_o=10 and ready 20 cycles later.
REQ-034 With the macro defined and drain_timeout_p=8, tx_busy_i stuck at 1 -> RESET entered after 8 DRAIN cycles and timeout_o pulses once; without the macro -> DRAIN held for 1000 cycles.

Source files
------------

// File: rtl/tx_clk_speed_sequencer.sv
// TX clock speed switch sequencer: drain MAC TX, reset clock generators, settle.
// Optional drain watchdog enabled by defining TX_CLK_SEQ_DRAIN_TIMEOUT_EN.
module tx_clk_speed_sequencer #(
   parameter int unsigned rst_cycles_p    = 4,
   parameter int unsigned settle_cycles_p = 16,
   parameter int unsigned drain_timeout_p = 4096
) (
   input  logic       clk250_i,
   input  logic       clk250_rst_ni,
   input  logic [1:0] speed_req_i,
   input  logic       speed_req_v_i,
   output logic       speed_req_ready_o,
   input  logic       tx_busy_i,
   output logic       tx_hold_o,
   output logic       clkgen_rst_o,
   output logic [1:0] clk_setting_o,
   output logic       link_ready_o,
   output logic       bad_req_o,
   output logic       timeout_o
);

   localparam int unsigned MAX_RS =
      (rst_cycles_p > settle_cycles_p) ? rst_cycles_p : settle_cycles_p;
   localparam int unsigned MAX_ALL =
      (MAX_RS > drain_timeout_p) ? MAX_RS : drain_timeout_p;
   localparam int unsigned CW = $clog2(MAX_ALL + 1);

   localparam logic [CW-1:0] RST_LD    = CW'(rst_cycles_p);
   localparam logic [CW-1:0] SETTLE_LD = CW'(settle_cycles_p);
   localparam logic [CW-1:0] ONE       = CW'(1);

   typedef enum logic [1:0] {
      S_READY,
      S_DRAIN,
      S_RESET,
      S_SETTLE
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic [1:0]    r_setting;
   logic [1:0]    w_setting_nxt;
   logic [1:0]    r_speed;
   logic [1:0]    w_speed_nxt;
   logic          r_bad;
   logic          w_bad_nxt;
   logic          w_to_nxt;

`ifdef TX_CLK_SEQ_DRAIN_TIMEOUT_EN
   localparam logic [CW-1:0] DRAIN_LD = CW'(drain_timeout_p);
   logic r_timeout;
`endif

   always_ff @(posedge clk250_i) begin
      if (!clk250_rst_ni) begin
         r_state   <= S_RESET;
         r_cnt     <= RST_LD;
         r_setting <= 2'b10;
         r_speed   <= 2'b10;
         r_bad     <= 1'b0;
`ifdef TX_CLK_SEQ_DRAIN_TIMEOUT_EN
         r_timeout <= 1'b0;
`endif
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_setting <= w_setting_nxt;
         r_speed   <= w_speed_nxt;
         r_bad     <= w_bad_nxt;
`ifdef TX_CLK_SEQ_DRAIN_TIMEOUT_EN
         r_timeout <= w_to_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_setting_nxt = r_setting;
      w_speed_nxt   = r_speed;
      w_bad_nxt     = 1'b0;
      w_to_nxt      = 1'b0;
      unique case (r_state)
         S_READY: begin
            if (speed_req_v_i) begin
               if (speed_req_i == 2'b11) begin
                  w_bad_nxt = 1'b1;
               end else if (speed_req_i != r_setting) begin
                  w_speed_nxt = speed_req_i;
                  w_state_nxt = S_DRAIN;
`ifdef TX_CLK_SEQ_DRAIN_TIMEOUT_EN
                  w_cnt_nxt   = DRAIN_LD;
`endif
               end
            end
         end
         S_DRAIN: begin
            if (!tx_busy_i) begin
               w_state_nxt   = S_RESET;
               w_cnt_nxt     = RST_LD;
               w_setting_nxt = r_speed;
            end
`ifdef TX_CLK_SEQ_DRAIN_TIMEOUT_EN
            else if (r_cnt == ONE) begin
               w_state_nxt   = S_RESET;
               w_cnt_nxt     = RST_LD;
               w_setting_nxt = r_speed;
               w_to_nxt      = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - ONE;
            end
`endif
         end
         S_RESET: begin
            if (r_cnt == ONE) begin
               w_state_nxt = S_SETTLE;
               w_cnt_nxt   = SETTLE_LD;
            end else begin
               w_cnt_nxt = r_cnt - ONE;
            end
         end
         S_SETTLE: begin
            if (r_cnt == ONE) begin
               w_state_nxt = S_READY;
            end else begin
               w_cnt_nxt = r_cnt - ONE;
            end
         end
         default: begin
            w_state_nxt = S_RESET;
            w_cnt_nxt   = RST_LD;
         end
      endcase
   end

   assign speed_req_ready_o = (r_state == S_READY);
   assign link_ready_o      = (r_state == S_READY);
   assign tx_hold_o         = (r_state != S_READY);
   assign clkgen_rst_o      = (r_state == S_RESET);
   assign clk_setting_o     = r_setting;
   assign bad_req_o         = r_bad;

`ifdef TX_CLK_SEQ_DRAIN_TIMEOUT_EN
   assign timeout_o = r_timeout;
`else
   assign timeout_o = 1'b0;
   logic w_unused;
   assign w_unused = w_to_nxt;
`endif

endmodule

// File: tb/tb_tx_clk_speed_sequencer.sv
// Directed bench for tx_clk_speed_sequencer: boot, switches, drain, reset, watchdog.
module tb_tx_clk_speed_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] req;
   logic       req_v;
   logic       req_rdy;
   logic       busy;
   logic       hold;
   logic       cg_rst;
   logic [1:0] setting;
   logic       link;
   logic       bad;
   logic       tmo;

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   tx_clk_speed_sequencer #(
      .rst_cycles_p(4),
      .settle_cycles_p(16),
      .drain_timeout_p(8)
   ) dut (
      .clk250_i(clk),
      .clk250_rst_ni(rst_n),
      .speed_req_i(req),
      .speed_req_v_i(req_v),
      .speed_req_ready_o(req_rdy),
      .tx_busy_i(busy),
      .tx_hold_o(hold),
      .clkgen_rst_o(cg_rst),
      .clk_setting_o(setting),
      .link_ready_o(link),
      .bad_req_o(bad),
      .timeout_o(tmo)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rst_checks();
      chk("rst_cg", int'(cg_rst), 1);
      chk("rst_hold", int'(hold), 1);
      chk("rst_link", int'(link), 0);
      chk("rst_rdy", int'(req_rdy), 0);
      chk("rst_set", int'(setting), 2);
      chk("rst_bad", int'(bad), 0);
      chk("rst_tmo", int'(tmo), 0);
   endtask

   task automatic boot();
      rst_n = 1'b1;
      for (int k = 0; k <= 20; k++) begin
         chk($sformatf("boot_cg%0d", k), int'(cg_rst), int'(k < 4));
         chk($sformatf("boot_lk%0d", k), int'(link), int'(k >= 20));
         chk($sformatf("boot_hd%0d", k), int'(hold), int'(k < 20));
         chk($sformatf("boot_st%0d", k), int'(setting), 2);
         if (k < 20) tick();
      end
   endtask

   initial begin
      int errs;
      rst_n = 1'b0;
      req   = 2'b00;
      req_v = 1'b0;
      busy  = 1'b0;
      tick();
      tick();
      tick();
      rst_checks();
      boot();

      // same-speed then reserved request
      req = 2'b10; req_v = 1'b1;
      chk("same_rdy", int'(req_rdy), 1);
      tick();
      req_v = 1'b0;
      chk("same_link", int'(link), 1);
      chk("same_bad", int'(bad), 0);
      chk("same_set", int'(setting), 2);
      req = 2'b11; req_v = 1'b1;
      tick();
      req_v = 1'b0;
      chk("res_bad", int'(bad), 1);
      chk("res_link", int'(link), 1);
      chk("res_set", int'(setting), 2);
      tick();
      chk("res_bad_end", int'(bad), 0);
      chk("res_link2", int'(link), 1);

      // switch to 100M, MAC idle
      req = 2'b01; req_v = 1'b1; busy = 1'b0;
      chk("sw_rdy", int'(req_rdy), 1);
      tick();
      req_v = 1'b0;
      chk("sw_dr_link", int'(link), 0);
      chk("sw_dr_hold", int'(hold), 1);
      chk("sw_dr_cg", int'(cg_rst), 0);
      chk("sw_dr_set", int'(setting), 2);
      for (int k = 2; k <= 22; k++) begin
         tick();
         chk($sformatf("sw_cg%0d", k), int'(cg_rst), int'(k <= 5));
         chk($sformatf("sw_st%0d", k), int'(setting), 1);
         chk($sformatf("sw_lk%0d", k), int'(link), int'(k >= 22));
      end

      // switch to 10M while MAC busy for 50 cycles
      req = 2'b00; req_v = 1'b1; busy = 1'b1;
      tick();
      req_v = 1'b0;
      errs = 0;
      for (int i = 1; i <= 51; i++) begin
         if (!(hold && !cg_rst && setting == 2'b01 && !req_rdy)) errs++;
         if (i < 51) tick();
      end
      chk("busy_drain", errs, 0);
      busy = 1'b0;
      tick();
      chk("busy_rel_cg", int'(cg_rst), 1);
      chk("busy_rel_set", int'(setting), 0);

      // reset during SETTLE of switch to 10M
      for (int i = 0; i < 6; i++) tick();
      chk("settle_cg", int'(cg_rst), 0);
      chk("settle_link", int'(link), 0);
      chk("settle_set", int'(setting), 0);
      rst_n = 1'b0;
      tick();
      rst_checks();
      boot();

      // MAC stuck busy
      req = 2'b01; req_v = 1'b1; busy = 1'b1;
      tick();
      req_v = 1'b0;
      errs = 0;
`ifdef TX_CLK_SEQ_DRAIN_TIMEOUT_EN
      for (int i = 1; i <= 8; i++) begin
         if (cg_rst || tmo || link || setting != 2'b10) errs++;
         if (i < 8) tick();
      end
      chk("wd_drain", errs, 0);
      tick();
      chk("wd_cg", int'(cg_rst), 1);
      chk("wd_tmo", int'(tmo), 1);
      chk("wd_set", int'(setting), 1);
      tick();
      chk("wd_tmo_end", int'(tmo), 0);
      chk("wd_cg2", int'(cg_rst), 1);
      busy = 1'b0;
`else
      for (int i = 1; i <= 1000; i++) begin
         if (cg_rst || tmo || link || setting != 2'b10) errs++;
         if (i < 1000) tick();
      end
      chk("stuck_drain", errs, 0);
      busy = 1'b0;
      tick();
      chk("stuck_rel_cg", int'(cg_rst), 1);
      chk("stuck_rel_tmo", int'(tmo), 0);
      chk("stuck_rel_set", int'(setting), 1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
